// File: rtl/tlb_op_ctrl_if.sv
// Port bundle between tlb_op_ctrl, the CP0 register file and the TLB array.
// op_valid/op_ready: a request transfers on a clock edge where op_valid && op_ready && !flush; op_ready is high only while idle.
interface tlb_op_ctrl_if #(
  parameter int TLBNUM = 16,
  parameter int IW     = $clog2(TLBNUM)
);
  logic          op_valid;
  logic [1:0]    op_type;
  logic          op_ready;
  logic          flush;
  logic          done;
  logic [89:0]   cp0_entry;
  logic [IW-1:0] cp0_index;
  logic [IW-1:0] cp0_wired;
  logic          cp0_wired_we;
  logic [18:0]   s_vpn2;
  logic [7:0]    s_asid;
  logic          s_odd_page;
  logic          s_found;
  logic [IW-1:0] s_index;
  logic [IW-1:0] r_index;
  logic [89:0]   r_entry;
  logic          we;
  logic [IW-1:0] w_index;
  logic [89:0]   w_entry;
  logic          idx_we;
  logic [31:0]   idx_val;
  logic          ent_we;
  logic [89:0]   ent_val;
  logic [IW-1:0] cp0_random;
  logic [2:0]    dbg_state;

  modport slave (
    input  op_valid, op_type, flush, cp0_entry, cp0_index, cp0_wired, cp0_wired_we,
           s_found, s_index, r_entry,
    output op_ready, done, s_vpn2, s_asid, s_odd_page, r_index, we, w_index, w_entry,
           idx_we, idx_val, ent_we, ent_val, cp0_random, dbg_state
  );

  modport master (
    output op_valid, op_type, flush, cp0_entry, cp0_index, cp0_wired, cp0_wired_we,
           s_found, s_index, r_entry,
    input  op_ready, done, s_vpn2, s_asid, s_odd_page, r_index, we, w_index, w_entry,
           idx_we, idx_val, ent_we, ent_val, cp0_random, dbg_state
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// TLBP/TLBR/TLBWI/TLBWR sequencer between CP0 and the TLB array, owner of the Random register.
// Define TLB_RANDOM_EN to enable the Random counter and TLBWR random indexing.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16
) (
  input logic          clk,
  input logic          resetn,
  tlb_op_ctrl_if.slave bus
);
  localparam int IW = $clog2(TLBNUM);
  localparam logic [IW-1:0] RMAX = IW'(TLBNUM - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_READ, S_WRITE, S_DONE} state_t;

  state_t        state, state_n;
  logic          accept;
  logic          done_n, we_n, idx_we_n, ent_we_n;
  logic          done_q, we_q, idx_we_q, ent_we_q;
  logic [89:0]   lat_entry;
  logic [IW-1:0] lat_index, lat_windex, wr_sel, rnd;
  logic [31:0]   idx_val_q;
  logic [89:0]   ent_val_q;

  assign accept = bus.op_valid && (state == S_IDLE) && !bus.flush;

`ifdef TLB_RANDOM_EN
  // Random reloads on a Wired write, on reaching Wired, or when Wired leaves no room to count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rnd <= RMAX;
    end else if (bus.cp0_wired_we || (bus.cp0_wired >= RMAX) || (rnd <= bus.cp0_wired)) begin
      rnd <= RMAX;
    end else begin
      rnd <= rnd - IW'(1);
    end
  end
  assign wr_sel = (bus.op_type == 2'b11) ? rnd : bus.cp0_index;
`else
  logic unused_wired;
  assign unused_wired = ^{bus.cp0_wired, bus.cp0_wired_we};
  assign rnd          = RMAX;
  assign wr_sel       = bus.cp0_index;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n  = state;
    done_n   = 1'b0;
    we_n     = 1'b0;
    idx_we_n = 1'b0;
    ent_we_n = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          case (bus.op_type)
            2'b00:   state_n = S_SEARCH;
            2'b01:   state_n = S_READ;
            default: begin
              state_n = S_WRITE;
              we_n    = 1'b1;
            end
          endcase
        end
      end
      S_SEARCH: begin
        if (bus.flush) state_n = S_IDLE;
        else begin
          state_n  = S_DONE;
          done_n   = 1'b1;
          idx_we_n = 1'b1;
        end
      end
      S_READ: begin
        if (bus.flush) state_n = S_IDLE;
        else begin
          state_n  = S_DONE;
          done_n   = 1'b1;
          ent_we_n = 1'b1;
        end
      end
      // The write strobe is already on the bus here, so flush can no longer cancel.
      S_WRITE: begin
        state_n = S_DONE;
        done_n  = 1'b1;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      idx_we_q   <= 1'b0;
      ent_we_q   <= 1'b0;
      lat_entry  <= '0;
      lat_index  <= '0;
      lat_windex <= '0;
      idx_val_q  <= '0;
      ent_val_q  <= '0;
    end else begin
      done_q   <= done_n;
      we_q     <= we_n;
      idx_we_q <= idx_we_n;
      ent_we_q <= ent_we_n;
      if (accept) begin
        lat_entry  <= bus.cp0_entry;
        lat_index  <= bus.cp0_index;
        lat_windex <= wr_sel;
      end
      if (idx_we_n) idx_val_q <= {~bus.s_found, {(31-IW){1'b0}}, bus.s_found ? bus.s_index : {IW{1'b0}}};
      if (ent_we_n) ent_val_q <= bus.r_entry;
    end
  end

  assign bus.op_ready   = (state == S_IDLE);
  assign bus.done       = done_q;
  assign bus.we         = we_q;
  assign bus.idx_we     = idx_we_q;
  assign bus.ent_we     = ent_we_q;
  assign bus.idx_val    = idx_val_q;
  assign bus.ent_val    = ent_val_q;
  assign bus.s_vpn2     = lat_entry[77:59];
  assign bus.s_asid     = lat_entry[58:51];
  assign bus.s_odd_page = 1'b0;
  assign bus.r_index    = lat_index;
  assign bus.w_index    = lat_windex;
  assign bus.w_entry    = lat_entry;
  assign bus.cp0_random = rnd;
  assign bus.dbg_state  = state;
endmodule
